// File: rtl/stop_watch_pkg.sv
// Shared types and constants for the stopwatch mode controller.
// Optional feature macro used by this slice: STOP_WATCH_LONG_PRESS_CLR_EN.
package stop_watch_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StLap  = 2'd2,
        StStop = 2'd3
    } sw_state_e;

    localparam logic [1:0] MODE_CLR  = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STOP = 2'b10;

    // Run-mode code the counter datapath expects for a given controller state.
    function automatic logic [1:0] state_mode(input sw_state_e st);
        case (st)
            StIdle:       return MODE_CLR;
            StRun, StLap: return MODE_RUN;
            default:      return MODE_STOP;
        endcase
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Button input path: 2-FF synchronizer, stability debounce, rising-edge press pulse.
// With STOP_WATCH_LONG_PRESS_CLR_EN the debounced level is also exported.
module sw_debounce #(
    parameter int unsigned DEB_CYC = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
`ifdef STOP_WATCH_LONG_PRESS_CLR_EN
    output logic o_level,
`endif
    output logic o_press
);

    localparam int unsigned CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_q;

    // Synchronize, then accept a new level only after DEB_CYC differing samples.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
        end else begin
            r_sync1   <= i_sw;
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_W'(DEB_CYC - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Press pulse is the debounced rise only; releases are silent.
    assign o_press = r_level & ~r_level_q;

`ifdef STOP_WATCH_LONG_PRESS_CLR_EN
    assign o_level = r_level;
`endif

endmodule

// File: rtl/stop_watch_ctrl.sv
// Stopwatch mode controller: debounced start/stop and lap/clear buttons drive an
// IDLE/RUN/LAP/STOP machine producing the counter mode, lap display hold, clear
// pulse and a saturating lap counter.
// Optional macro STOP_WATCH_LONG_PRESS_CLR_EN: holding start/stop for LONG_CYC
// cycles clears the stopwatch from any non-idle state.
module stop_watch_ctrl
    import stop_watch_pkg::*;
#(
    parameter int unsigned DEB_CYC  = 20,
    parameter int unsigned LAP_W    = 4,
    parameter int unsigned LONG_CYC = 2000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SW_S,
    input  logic             SW_L,
    output logic [1:0]       SW_S_MODE,
    output logic             DISP_HOLD,
    output logic             CLR_P,
    output logic [LAP_W-1:0] LAP_CNT
);

    logic      w_s_press;
    logic      w_l_press;
    sw_state_e r_state;
    sw_state_e w_next;
    logic      w_lap_inc;
    logic      w_clr;

`ifdef STOP_WATCH_LONG_PRESS_CLR_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);

    logic              w_s_lvl;
    logic              w_l_lvl;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              w_long_fire;
`endif

    sw_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_deb_s (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_sw    (SW_S),
`ifdef STOP_WATCH_LONG_PRESS_CLR_EN
        .o_level (w_s_lvl),
`endif
        .o_press (w_s_press)
    );

    sw_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_deb_l (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_sw    (SW_L),
`ifdef STOP_WATCH_LONG_PRESS_CLR_EN
        .o_level (w_l_lvl),
`endif
        .o_press (w_l_press)
    );

`ifdef STOP_WATCH_LONG_PRESS_CLR_EN
    // Count cycles of continuous start/stop hold; saturating so it fires once per hold.
    always_ff @(posedge CLK) begin
        if (RESET || !w_s_lvl) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt != HOLD_W'(LONG_CYC)) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end

    assign w_long_fire = w_s_lvl && (r_hold_cnt == HOLD_W'(LONG_CYC - 1));
`endif

    // Next-state decode; start/stop beats lap/clear when both arrive together.
    always_comb begin
        w_next    = r_state;
        w_lap_inc = 1'b0;
        w_clr     = 1'b0;
`ifdef STOP_WATCH_LONG_PRESS_CLR_EN
        if (w_long_fire && (r_state != StIdle)) begin
            w_next = StIdle;
            w_clr  = 1'b1;
        end else
`endif
        if (w_s_press) begin
            unique case (r_state)
                StIdle: w_next = StRun;
                StRun:  w_next = StStop;
                StLap:  w_next = StStop;
                StStop: w_next = StRun;
            endcase
        end else if (w_l_press) begin
            unique case (r_state)
                StIdle: w_next = StIdle;
                StRun: begin
                    w_next    = StLap;
                    w_lap_inc = 1'b1;
                end
                StLap: begin
                    w_next    = StRun;
                    w_lap_inc = 1'b1;
                end
                StStop: begin
                    w_next = StIdle;
                    w_clr  = 1'b1;
                end
            endcase
        end
    end

    // State and all outputs registered together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= StIdle;
            SW_S_MODE <= MODE_CLR;
            DISP_HOLD <= 1'b0;
            CLR_P     <= 1'b0;
            LAP_CNT   <= '0;
        end else begin
            r_state   <= w_next;
            SW_S_MODE <= state_mode(w_next);
            DISP_HOLD <= (w_next == StLap);
            CLR_P     <= w_clr;
            if (w_clr) begin
                LAP_CNT <= '0;
            end else if (w_lap_inc && (LAP_CNT != {LAP_W{1'b1}})) begin
                LAP_CNT <= LAP_CNT + LAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Self-checking bench for stop_watch_ctrl: directed scenarios plus random button
// activity, every cycle compared with a behavioural model of the controller.
module tb_stop_watch_ctrl;

    localparam int DEB  = 4;
    localparam int LAPW = 4;
    localparam int LONG = 50;
    localparam int LAP_MAX = (1 << LAPW) - 1;
`ifdef STOP_WATCH_LONG_PRESS_CLR_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_LAP  = 2;
    localparam int M_STOP = 3;

    logic            CLK;
    logic            RESET;
    logic            SW_S;
    logic            SW_L;
    logic [1:0]      SW_S_MODE;
    logic            DISP_HOLD;
    logic            CLR_P;
    logic [LAPW-1:0] LAP_CNT;

    int n_chk;
    int n_err;
    int clr_hits;

    // Model state
    int   q_s[$];
    int   q_l[$];
    bit   lv_s, lv_sp, lv_l, lv_lp;
    int   run_s;
    int   m_st;
    int   e_mode;
    int   e_hold;
    int   e_clr;
    int   e_lap;

    stop_watch_ctrl #(
        .DEB_CYC  (DEB),
        .LAP_W    (LAPW),
        .LONG_CYC (LONG)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SW_S      (SW_S),
        .SW_L      (SW_L),
        .SW_S_MODE (SW_S_MODE),
        .DISP_HOLD (DISP_HOLD),
        .CLR_P     (CLR_P),
        .LAP_CNT   (LAP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Level flips once the last DEB synchronized samples (raw delayed two edges)
    // all disagree with it.
    function automatic bit deb_level(input int h[$], input bit lv);
        int n;
        n = h.size();
        for (int i = 0; i < DEB; i++) begin
            if (h[n - 3 - i] == int'(lv)) return lv;
        end
        return !lv;
    endfunction

    task automatic model_edge(input bit rst, input bit s, input bit l);
        bit ps;
        bit pl;
        bit lg;
        if (rst) begin
            m_st  = M_IDLE;
            e_clr = 0;
            e_lap = 0;
            lv_s  = 0;
            lv_sp = 0;
            lv_l  = 0;
            lv_lp = 0;
            run_s = 0;
            q_s.delete();
            q_l.delete();
            for (int i = 0; i < 16; i++) begin
                q_s.push_back(0);
                q_l.push_back(0);
            end
        end else begin
            ps = lv_s && !lv_sp;
            pl = lv_l && !lv_lp;
            lg = LONG_EN && (run_s == LONG);
            e_clr = 0;
            if (lg && m_st != M_IDLE) begin
                m_st  = M_IDLE;
                e_clr = 1;
                e_lap = 0;
            end else if (ps) begin
                m_st = (m_st == M_IDLE || m_st == M_STOP) ? M_RUN : M_STOP;
            end else if (pl) begin
                if (m_st == M_RUN || m_st == M_LAP) begin
                    m_st  = (m_st == M_RUN) ? M_LAP : M_RUN;
                    e_lap = (e_lap < LAP_MAX) ? e_lap + 1 : LAP_MAX;
                end else if (m_st == M_STOP) begin
                    m_st  = M_IDLE;
                    e_clr = 1;
                    e_lap = 0;
                end
            end
            lv_sp = lv_s;
            lv_lp = lv_l;
            q_s.push_back(int'(s));
            q_l.push_back(int'(l));
            if (q_s.size() > 16) void'(q_s.pop_front());
            if (q_l.size() > 16) void'(q_l.pop_front());
            lv_s  = deb_level(q_s, lv_s);
            lv_l  = deb_level(q_l, lv_l);
            run_s = lv_s ? run_s + 1 : 0;
        end
        e_mode = (m_st == M_IDLE) ? 0 : (m_st == M_STOP) ? 2 : 1;
        e_hold = (m_st == M_LAP) ? 1 : 0;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge(RESET, SW_S, SW_L);
        #1;
        chk("mode", 32'(SW_S_MODE), 32'(e_mode));
        chk("hold", 32'(DISP_HOLD), 32'(e_hold));
        chk("clr",  32'(CLR_P),     32'(e_clr));
        chk("lap",  32'(LAP_CNT),   32'(e_lap));
        if (CLR_P) clr_hits++;
    endtask

    task automatic press(input bit s, input bit l);
        SW_S = s;
        SW_L = l;
        repeat (DEB + 3) step();
        SW_S = 1'b0;
        SW_L = 1'b0;
        repeat (DEB + 3) step();
    endtask

    initial begin
        int c0;
        int r;
        n_chk    = 0;
        n_err    = 0;
        clr_hits = 0;
        RESET    = 1'b1;
        SW_S     = 1'b0;
        SW_L     = 1'b0;

        // Reset for edges 1-2, start/stop raised for edge 10
        step();
        step();
        chk("rst_mode", 32'(SW_S_MODE), 32'd0);
        chk("rst_hold", 32'(DISP_HOLD), 32'd0);
        chk("rst_clr",  32'(CLR_P),     32'd0);
        chk("rst_lap",  32'(LAP_CNT),   32'd0);
        RESET = 1'b0;
        repeat (7) step();
        SW_S = 1'b1;
        repeat (DEB + 2) step();
        chk("latency_e15", 32'(SW_S_MODE), 32'd0);
        step();
        chk("latency_e16", 32'(SW_S_MODE), 32'd1);
        SW_S = 1'b0;
        repeat (8) step();

        // Short glitch in RUN
        SW_S = 1'b1;
        repeat (DEB - 1) step();
        SW_S = 1'b0;
        repeat (10) step();
        chk("glitch_mode", 32'(SW_S_MODE), 32'd1);

        // Three laps
        press(1'b0, 1'b1);
        chk("lap1_hold", 32'(DISP_HOLD), 32'd1);
        chk("lap1_cnt",  32'(LAP_CNT),   32'd1);
        press(1'b0, 1'b1);
        chk("lap2_hold", 32'(DISP_HOLD), 32'd0);
        chk("lap2_cnt",  32'(LAP_CNT),   32'd2);
        press(1'b0, 1'b1);
        chk("lap3_hold", 32'(DISP_HOLD), 32'd1);
        chk("lap3_cnt",  32'(LAP_CNT),   32'd3);
        chk("lap3_mode", 32'(SW_S_MODE), 32'd1);

        // Stop, then clear
        press(1'b1, 1'b0);
        chk("stop_mode", 32'(SW_S_MODE), 32'd2);
        chk("stop_hold", 32'(DISP_HOLD), 32'd0);
        c0 = clr_hits;
        press(1'b0, 1'b1);
        chk("clear_mode",   32'(SW_S_MODE),     32'd0);
        chk("clear_pulses", 32'(clr_hits - c0), 32'd1);
        chk("clear_lap",    32'(LAP_CNT),       32'd0);

        // Simultaneous presses from RUN with two laps recorded
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b1, 1'b1);
        chk("simul_mode", 32'(SW_S_MODE), 32'd2);
        chk("simul_lap",  32'(LAP_CNT),   32'd2);
        chk("simul_hold", 32'(DISP_HOLD), 32'd0);

        // Reset lands on the same edge as a start/stop press in STOP
        c0 = clr_hits;
        SW_S = 1'b1;
        repeat (DEB + 2) step();
        RESET = 1'b1;
        step();
        chk("rstpress_mode", 32'(SW_S_MODE), 32'd0);
        chk("rstpress_clr",  32'(CLR_P),     32'd0);
        RESET = 1'b0;
        SW_S  = 1'b0;
        repeat (8) step();
        chk("rstpress_idle", 32'(SW_S_MODE),     32'd0);
        chk("rstpress_noclr", 32'(clr_hits - c0), 32'd0);

        // Lap counter saturation
        press(1'b1, 1'b0);
        repeat (20) press(1'b0, 1'b1);
        chk("sat_lap",  32'(LAP_CNT),   32'(LAP_MAX));
        chk("sat_hold", 32'(DISP_HOLD), 32'd0);
        press(1'b0, 1'b1);
        chk("sat_lap2",  32'(LAP_CNT),   32'(LAP_MAX));
        chk("sat_hold2", 32'(DISP_HOLD), 32'd1);

        // Long hold of start/stop from LAP
        c0 = clr_hits;
        SW_S = 1'b1;
        repeat (LONG + 30) step();
        SW_S = 1'b0;
        repeat (8) step();
        chk("long_pulses", 32'(clr_hits - c0), LONG_EN ? 32'd1 : 32'd0);
        chk("long_mode",   32'(SW_S_MODE),     LONG_EN ? 32'd0 : 32'd2);

        // Random button activity with occasional resets
        for (int seg = 0; seg < 400; seg++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                RESET = 1'b1;
                step();
                RESET = 1'b0;
            end else begin
                SW_S = ($urandom_range(0, 2) == 0);
                SW_L = ($urandom_range(0, 2) == 0);
                repeat ($urandom_range(1, 12)) step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/stop_watch_ctrl.md
Name: stop_watch_ctrl

Overview:
Mode controller for the stopwatch counter datapath (centisecond/second/minute chain).
- Turns two raw push-buttons (start/stop, lap/clear) into the 2-bit run-mode code the counter consumes.
- Also produces a display-hold flag for lap freeze, a one-cycle clear pulse and a lap counter.
- Sits between the board buttons and the stopwatch counter/BCD-split path; replaces ad-hoc single-button mode toggling.

Parameters:
- DEB_CYC, 4'd? -> integer 20: consecutive stable CLK samples required to accept a button level change.
- LAP_W, 4: width of lap counter.
- LONG_CYC, 2000: hold time in CLK cycles for long-press clear (optional feature only).

Ports:
- CLK  in  1  system clock (1 kHz tick domain of the stopwatch counter)
- RESET  in  1  reset, synchronous, active-high
- SW_S  in  1  raw start/stop button, asynchronous, active-high
- SW_L  in  1  raw lap/clear button, asynchronous, active-high
- SW_S_MODE  out  2  counter mode: 00 clear/idle, 01 run, 10 stop; 11 never driven
- DISP_HOLD  out  1  1 = display latch frozen (lap view)
- CLR_P  out  1  one-cycle pulse when stopwatch is cleared
- LAP_CNT  out  LAP_W  number of laps taken since last clear, saturating

Behaviour:
- Reset (sync, RESET=1 at rising CLK):
  - state IDLE, SW_S_MODE=00, DISP_HOLD=0, CLR_P=0, LAP_CNT=0.
  - Synchronizers, debounce counters and debounced levels all 0.
  - Reset asserted mid-operation overrides every press in that cycle.
- Input path, per button, identical:
  - 2-FF synchronizer.
  - Debounce counter increments while sync output differs from the debounced level; it is cleared to 0 when they agree.
  - When the count reaches DEB_CYC-1 and the inputs still differ, the debounced level flips and the counter clears.
  - Press pulse = debounced rising edge, exactly 1 cycle.
  - Releases produce no pulse.
- Latency: raw input high and stable from sampling edge k -> debounced level high at edge k+DEB_CYC+1 -> FSM state/outputs update at edge k+DEB_CYC+2.
- Glitches shorter than DEB_CYC samples are ignored completely.
- FSM, registered outputs:
  - IDLE (mode 00): S press -> RUN. L press -> stay IDLE, no pulse.
  - RUN (mode 01): S press -> STOP. L press -> LAP, LAP_CNT+1.
  - LAP (mode 01, DISP_HOLD=1): S press -> STOP, hold released. L press -> RUN (hold released, LAP_CNT+1, new lap recorded).
  - STOP (mode 10): S press -> RUN. L press -> IDLE, CLR_P=1 for that one cycle, LAP_CNT cleared to 0.
- Simultaneous S and L press in the same cycle: S wins; L is discarded, not queued.
- LAP_CNT saturates at 2^LAP_W-1; further laps still toggle DISP_HOLD but do not wrap.
- DISP_HOLD=1 only in LAP; CLR_P=1 only on the STOP->IDLE transition cycle.

Optional Feature:
- Macro: STOP_WATCH_LONG_PRESS_CLR_EN.
- Defined:
  - SW_S debounced level continuously high for LONG_CYC cycles, from any state other than IDLE -> IDLE, CLR_P pulse, LAP_CNT=0.
  - The long press fires once per hold.
  - The initial press pulse has already acted normally.
  - A hold counter saturates until release.
- Undefined: no hold counter; long presses behave as a single press.

Decomposition:
- Package stop_watch_pkg holds:
  - State enum: IDLE, RUN, LAP, STOP.
  - Mode constants: MODE_CLR=2'b00, MODE_RUN=2'b01, MODE_STOP=2'b10.
- Sub-module sw_debounce: sync + debounce + rise-pulse, parameter DEB_CYC, instantiated once per button.
- The FSM and lap counter stay in stop_watch_ctrl.

Test Plan:
- DEB_CYC=4; RESET high 2 cycles, then SW_S held high from edge 10 -> SW_S_MODE 00 until edge 15, 01 at edge 16; all other outputs at reset values before.
- SW_S pulsed high for 3 cycles (shorter than DEB_CYC) in RUN -> no state change, SW_S_MODE stays 01.
- Sequence RUN, L, L, L -> DISP_HOLD 1,0,1 after each respective press; LAP_CNT 1,2,3; SW_S_MODE 01 throughout.
- RUN, S (STOP, mode 10), L -> mode 00, CLR_P high exactly 1 cycle, LAP_CNT 0.
- S and L presses debounced on the same edge in RUN -> STOP (mode 10), LAP_CNT unchanged, DISP_HOLD 0.
- RESET asserted on the same edge an S press arrives in STOP -> IDLE, mode 00, no CLR_P.
- With STOP_WATCH_LONG_PRESS_CLR_EN, LONG_CYC=50: hold SW_S from RUN -> STOP after debounce, IDLE with CLR_P 50 cycles after debounced rise; keep holding -> no second pulse.
